// File: rtl/conv_1d_pkg.sv
// Shared types and helpers for the BRAM-fed 1-D convolution.
// State enum, accumulator width and result reduction.
package conv_1d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ACC,
    S_WR,
    S_DONE
  } state_t;

  // Accumulator wide enough for IMG_D*FILTER_L full products.
  function automatic int acc_w(
    input int dw,
    input int d,
    input int l
  );
    return 2 * dw + $clog2(d * l + 1);
  endfunction

  // Clamp to signed dw bits when sat is set; caller keeps low dw bits.
  function automatic logic [63:0] reduce(
    input logic signed [63:0] v,
    input int                 dw,
    input int                 sat
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat != 0 && v > hi) return hi;
    if (sat != 0 && v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_bram_1d_pad_mac.sv
// One output channel: latched filter, accumulator and reduction.
// Ports: load/fil latch weights, clear/add/tap/pix drive the MAC, result out.
module conv_bram_1d_pad_mac
  import conv_1d_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_D      = 4,
  parameter int FILTER_L   = 3,
  parameter int SATURATE   = 0,
  parameter int TAP_W      = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic                               clear,
  input  logic                               add,
  input  logic [TAP_W-1:0]                   tap,
  input  logic [DATA_WIDTH*IMG_D*FILTER_L-1:0] fil,
  input  logic [DATA_WIDTH*IMG_D-1:0]        pix,
  output logic [DATA_WIDTH-1:0]              result
);

  localparam int ACC_W = acc_w(DATA_WIDTH, IMG_D, FILTER_L);

  logic [DATA_WIDTH*IMG_D*FILTER_L-1:0] wt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] a;
  logic signed [ACC_W-1:0] b;

  always_comb begin
    sum = '0;
    a   = '0;
    b   = '0;
    for (int d = 0; d < IMG_D; d++) begin
      a = ACC_W'($signed(
        wt[(d*FILTER_L+int'(tap))*DATA_WIDTH +: DATA_WIDTH]));
      b = ACC_W'($signed(pix[d*DATA_WIDTH +: DATA_WIDTH]));
      sum = sum + a * b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wt  <= '0;
      acc <= '0;
    end else begin
      if (load) wt <= fil;
      if (clear) acc <= '0;
      else if (add) acc <= acc + sum;
    end
  end

  assign result =
    DATA_WIDTH'(reduce(64'(acc), DATA_WIDTH, SATURATE));

endmodule

// File: rtl/conv_bram_1d_pad.sv
// 1-D multi-channel convolution over BRAM images with zero padding.
// Ports: fil weights, val_in/rdy_in start, img_* BRAM read, result_* write, done.
module conv_bram_1d_pad
  import conv_1d_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_D      = 4,
  parameter int FILTER_L   = 3,
  parameter int RESULT_D   = 4,
  parameter int STRIDE_W   = 1,
  parameter int DILATION   = 1,
  parameter int PAD        = 0,
  parameter int SATURATE   = 0,
  localparam int RESULT_W =
    (IMG_W + 2*PAD - DILATION*(FILTER_L-1) - 1) / STRIDE_W + 1,
  localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
  localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W)
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_WIDTH*RESULT_D*IMG_D*FILTER_L-1:0] fil,
  input  logic val_in,
  output logic rdy_in,
  output logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0] img_rdaddr,
  input  logic [DATA_WIDTH*IMG_D-1:0] img_rddata,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddr,
  output logic [DATA_WIDTH*RESULT_D-1:0] result_wrdata,
  output logic [RESULT_D-1:0] result_wren,
  output logic done
);

  localparam int IA = IMG_RAM_ADDR_WIDTH;
  localparam int RA = RESULT_RAM_ADDR_WIDTH;
  localparam int LW = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;
  localparam int FB = DATA_WIDTH * IMG_D * FILTER_L;

  state_t state;
  state_t nxt;

  logic [RA-1:0] w;
  logic [LW-1:0] l;
  logic [LW-1:0] tap_q;
  logic [IA-1:0] addr;
  logic [IA-1:0] addr_q;
  logic          add_q;
  logic          hit;
  logic          accept;
  logic          wr;
  int            col;

  logic [DATA_WIDTH-1:0] res [RESULT_D];

  assign accept = (state == S_IDLE) && val_in;
  assign wr     = (state == S_WR);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (val_in) nxt = S_RUN;
      S_RUN:  if (l == LW'(FILTER_L-1)) nxt = S_ACC;
      S_ACC:  nxt = S_WR;
      S_WR:   nxt = (w == RA'(RESULT_W-1)) ? S_DONE : S_RUN;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Padded taps keep the last address so no out-of-image read is issued.
  always_comb begin
    col  = int'(w) * STRIDE_W + int'(l) * DILATION - PAD;
    hit  = (col >= 0) && (col < IMG_W);
    addr = addr_q;
    if (state == S_RUN && hit) addr = IA'(col);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      w      <= '0;
      l      <= '0;
      tap_q  <= '0;
      addr_q <= '0;
      add_q  <= 1'b0;
    end else begin
      state  <= nxt;
      addr_q <= addr;
      tap_q  <= l;
      add_q  <= (state == S_RUN) && hit;
      if (state == S_IDLE) begin
        w <= '0;
        l <= '0;
      end
      if (state == S_RUN)
        l <= (l == LW'(FILTER_L-1)) ? '0 : l + 1'b1;
      if (wr && w != RA'(RESULT_W-1))
        w <= w + 1'b1;
    end
  end

  for (genvar k = 0; k < RESULT_D; k++) begin : g_mac
    conv_bram_1d_pad_mac #(
      .DATA_WIDTH(DATA_WIDTH),
      .IMG_D     (IMG_D),
      .FILTER_L  (FILTER_L),
      .SATURATE  (SATURATE),
      .TAP_W     (LW)
    ) u_mac (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .clear (accept || wr),
      .add   (add_q),
      .tap   (tap_q),
      .fil   (fil[k*FB +: FB]),
      .pix   (img_rddata),
      .result(res[k])
    );
    assign result_wrdata[k*DATA_WIDTH +: DATA_WIDTH] =
      wr ? res[k] : '0;
  end

  assign img_rdaddr    = {IMG_D{addr}};
  assign result_wraddr = {RESULT_D{w}};
  assign result_wren   = {RESULT_D{wr}};
  assign rdy_in        = (state == S_IDLE);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_conv_bram_1d_pad.sv
// Directed bench for conv_bram_1d_pad over four parameter sets.
// Base/handshake/back-to-back, padding, stride+dilation, saturation.
module tb_conv_bram_1d_pad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nbad = 0;

  function automatic void chk(string nm, longint act, longint exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  typedef struct {
    string name;
    int    unit;
    int    k;
    int    w;
    int    exp;
  } vec_t;

  function automatic vec_t mk(string n, int u, int k, int w, int e);
    vec_t v;
    v.name = n; v.unit = u; v.k = k; v.w = w; v.exp = e;
    return v;
  endfunction

  // base instance: defaults
  logic [383:0] fil_b;
  logic         val_b, rdy_b, done_b;
  logic [19:0]  ia_b, wa_b;
  logic [31:0]  rd_b, wd_b;
  logic [3:0]   we_b;
  logic [7:0]   mem_b [4][32];

  conv_bram_1d_pad u_b (
    .clk(clk), .reset(reset), .fil(fil_b),
    .val_in(val_b), .rdy_in(rdy_b),
    .img_rdaddr(ia_b), .img_rddata(rd_b),
    .result_wraddr(wa_b), .result_wrdata(wd_b),
    .result_wren(we_b), .done(done_b)
  );

  always @(posedge clk)
    for (int d = 0; d < 4; d++)
      rd_b[d*8 +: 8] <= mem_b[d][ia_b[d*5 +: 5]];

  int a_b = 0, nw_b = 0, td_b = 0, dc_b = 0;
  int res_b [4][32];

  always @(negedge clk) begin
    if (val_b && rdy_b) begin a_b = cyc; nw_b = 0; end
    if (we_b != 4'h0) begin
      chk("b_wren_all", we_b, 15);
      chk("b_wr_time", cyc, a_b + 5 + 5*nw_b);
      for (int k = 0; k < 4; k++) begin
        chk("b_wraddr", wa_b[k*5 +: 5], nw_b);
        if (nw_b < 32) res_b[k][nw_b] = int'(wd_b[k*8 +: 8]);
      end
      nw_b++;
    end
    if (done_b) begin
      chk("b_done_time", cyc, a_b + 151);
      chk("b_writes_at_done", nw_b, 30);
      td_b++;
      dc_b = cyc;
    end
  end

  // pad instance: IMG_W=8, PAD=1
  logic [383:0] fil_p;
  logic         val_p, rdy_p, done_p;
  logic [11:0]  ia_p, wa_p;
  logic [31:0]  rd_p, wd_p;
  logic [3:0]   we_p;

  conv_bram_1d_pad #(.IMG_W(8), .PAD(1)) u_p (
    .clk(clk), .reset(reset), .fil(fil_p),
    .val_in(val_p), .rdy_in(rdy_p),
    .img_rdaddr(ia_p), .img_rddata(rd_p),
    .result_wraddr(wa_p), .result_wrdata(wd_p),
    .result_wren(we_p), .done(done_p)
  );

  always @(posedge clk)
    for (int d = 0; d < 4; d++) rd_p[d*8 +: 8] <= 8'd1;

  int a_p = -100, td_p = 0, n_p, col_p, ma_p = 0;
  int res_p [4][8];

  always @(negedge clk) begin
    if (val_p && rdy_p) a_p = cyc;
    n_p = cyc - a_p - 1;
    if (n_p >= 0 && n_p < 40 && n_p % 5 < 3) begin
      col_p = n_p / 5 + n_p % 5 - 1;
      if (col_p >= 0 && col_p < 8) ma_p = col_p;
      for (int d = 0; d < 4; d++)
        chk("p_rdaddr", ia_p[d*3 +: 3], ma_p);
    end
    if (we_p[0])
      for (int k = 0; k < 4; k++)
        res_p[k][wa_p[k*3 +: 3]] = int'(wd_p[k*8 +: 8]);
    if (done_p) begin
      chk("p_done_time", cyc, a_p + 41);
      td_p++;
    end
  end

  // stride/dilation instance
  logic [23:0] fil_s;
  logic        val_s, rdy_s, done_s;
  logic [3:0]  ia_s;
  logic [2:0]  wa_s;
  logic [7:0]  rd_s, wd_s;
  logic [0:0]  we_s;
  logic [7:0]  mem_s [16];

  conv_bram_1d_pad #(
    .IMG_W(16), .IMG_D(1), .RESULT_D(1),
    .STRIDE_W(2), .DILATION(2)
  ) u_s (
    .clk(clk), .reset(reset), .fil(fil_s),
    .val_in(val_s), .rdy_in(rdy_s),
    .img_rdaddr(ia_s), .img_rddata(rd_s),
    .result_wraddr(wa_s), .result_wrdata(wd_s),
    .result_wren(we_s), .done(done_s)
  );

  always @(posedge clk) rd_s <= mem_s[ia_s];

  int td_s = 0;
  int res_s [8];

  always @(negedge clk) begin
    if (we_s[0]) res_s[wa_s] = int'(wd_s);
    if (done_s) td_s++;
  end

  // saturating instance
  logic [383:0] fil_t;
  logic         val_t, rdy_t, done_t;
  logic [11:0]  ia_t, wa_t;
  logic [31:0]  rd_t, wd_t;
  logic [3:0]   we_t;

  conv_bram_1d_pad #(.IMG_W(8), .SATURATE(1)) u_t (
    .clk(clk), .reset(reset), .fil(fil_t),
    .val_in(val_t), .rdy_in(rdy_t),
    .img_rdaddr(ia_t), .img_rddata(rd_t),
    .result_wraddr(wa_t), .result_wrdata(wd_t),
    .result_wren(we_t), .done(done_t)
  );

  always @(posedge clk) rd_t <= {4{8'h7F}};

  int td_t = 0;
  int res_t [4][8];

  always @(negedge clk) begin
    if (we_t[0])
      for (int k = 0; k < 4; k++)
        res_t[k][wa_t[k*3 +: 3]] = int'(wd_t[k*8 +: 8]);
    if (done_t) td_t++;
  end

  task automatic fill_b(input logic [7:0] v);
    for (int d = 0; d < 4; d++)
      for (int x = 0; x < 32; x++) mem_b[d][x] = v;
    for (int k = 0; k < 4; k++)
      for (int x = 0; x < 32; x++) res_b[k][x] = -1;
  endtask

  task automatic wait_td_b(input int target);
    for (int i = 0; i < 400 && td_b < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk("b_done_seen", td_b, target);
  endtask

  task automatic chk_b(string nm, input int exp);
    for (int k = 0; k < 4; k++)
      for (int x = 0; x < 30; x++) chk(nm, res_b[k][x], exp);
  endtask

  initial begin
    vec_t tbl[$];
    int   act;
    int   td0;

    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 30; w++)
        tbl.push_back(mk("base_ones", 0, k, w, 12));
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 8; w++)
        tbl.push_back(mk("pad_ones", 1, k, w,
                         (w == 0 || w == 7) ? 8 : 12));
    for (int w = 0; w < 6; w++)
      tbl.push_back(mk("stride_dil", 2, 0, w, 6*w + 6));
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 6; w++)
        tbl.push_back(mk("sat_clamp", 3, k, w, 127));

    reset = 1'b0;
    val_b = 0; val_p = 0; val_s = 0; val_t = 0;
    fil_b = '0; fil_p = '0; fil_s = '0; fil_t = '0;
    fill_b(8'd1);
    for (int x = 0; x < 16; x++) mem_s[x] = 8'(x);
    for (int x = 0; x < 8; x++) begin
      res_s[x] = -1;
      for (int k = 0; k < 4; k++) begin
        res_p[k][x] = -1;
        res_t[k][x] = -1;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_in", rdy_b, 1);
    chk("rst_done", done_b, 0);
    chk("rst_wren", we_b, 0);
    chk("rst_rdaddr", ia_b, 0);
    chk("rst_wraddr", wa_b, 0);
    chk("rst_wrdata", wd_b, 0);
    chk("rst_pad_rdy", rdy_p, 1);
    @(posedge clk);
    #1 reset = 1'b1;

    // all four units run their first job together
    fil_b = {48{8'd1}};
    fil_p = {48{8'd1}};
    fil_s = {3{8'd1}};
    fil_t = {48{8'h7F}};
    @(posedge clk);
    #1 begin val_b = 1; val_p = 1; val_s = 1; val_t = 1; end
    @(posedge clk);
    #1 begin val_b = 0; val_p = 0; val_s = 0; val_t = 0; end
    wait_td_b(1);
    chk("p_done_seen", td_p, 1);
    chk("s_done_seen", td_s, 1);
    chk("t_done_seen", td_t, 1);

    foreach (tbl[i]) begin
      case (tbl[i].unit)
        0:       act = res_b[tbl[i].k][tbl[i].w];
        1:       act = res_p[tbl[i].k][tbl[i].w];
        2:       act = res_s[tbl[i].w];
        default: act = res_t[tbl[i].k][tbl[i].w];
      endcase
      chk(tbl[i].name, act, tbl[i].exp);
    end

    // wrap: 12*127*127 = 193548, low byte 12
    fill_b(8'h7F);
    fil_b = {48{8'h7F}};
    @(posedge clk);
    #1 val_b = 1;
    @(posedge clk);
    #1 val_b = 0;
    wait_td_b(2);
    chk_b("wrap_127", 12);

    // busy val_in ignored, then reset during RUN of output 3
    fill_b(8'd1);
    fil_b = {48{8'd1}};
    @(posedge clk);
    #1 val_b = 1;
    @(posedge clk);
    #1 val_b = 0;
    repeat (4) @(posedge clk);
    #1 val_b = 1;
    @(negedge clk);
    chk("busy_rdy_in", rdy_b, 0);
    @(posedge clk);
    #1 val_b = 0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    td0 = td_b;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_rdy_in", rdy_b, 1);
    chk("abort_wren", we_b, 0);
    chk("abort_done", done_b, 0);
    repeat (200) @(negedge clk);
    chk("abort_writes", nw_b, 3);
    chk("abort_no_done", td_b, td0);
    chk("abort_res2", res_b[0][2], 12);
    chk("abort_res3", res_b[0][3], -1);

    // back-to-back with weights changed mid-job
    fill_b(8'd1);
    @(posedge clk);
    #1 val_b = 1;
    repeat (20) @(posedge clk);
    #1 fil_b = {48{8'd2}};
    wait_td_b(td0 + 1);
    chk_b("b2b_job1", 12);
    fill_b(8'd1);
    @(posedge clk);
    @(posedge clk);
    #1 val_b = 0;
    chk("b2b_accept", a_b, dc_b + 1);
    repeat (20) @(posedge clk);
    #1 fil_b = {48{8'd1}};
    wait_td_b(td0 + 2);
    chk_b("b2b_job2", 24);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/conv_bram_1d_pad.md
CONV_BRAM_1D_PAD -- requirements
Module: conv_bram_1d_pad

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed two's-complement width of pixels, weights and results.
REQ-002 SHALL have parameter IMG_W, default 32: image width in columns.
REQ-003 SHALL have parameter IMG_D, default 4: input channel count.
REQ-004 SHALL have parameter FILTER_L, default 3: filter taps.
REQ-005 SHALL have parameter RESULT_D, default 4: filter/output channel count.
REQ-006 SHALL have parameter STRIDE_W, default 1: output step, at least 1.
REQ-007 SHALL have parameter DILATION, default 1: tap spacing, at least 1.
REQ-008 SHALL have parameter PAD, default 0: zero columns on each image edge, 0 to FILTER_L-1.
REQ-009 SHALL have parameter SATURATE, default 0: 0 keeps the low DATA_WIDTH bits, 1 clamps to the signed DATA_WIDTH range.
REQ-010 SHALL derive RESULT_W = (IMG_W+2*PAD-DILATION*(FILTER_L-1)-1)/STRIDE_W+1, and address widths IMG_RAM_ADDR_WIDTH=$clog2(IMG_W) and RESULT_RAM_ADDR_WIDTH=$clog2(RESULT_W).
REQ-011 SHALL have port clk, input, 1 bit: the single clock.
REQ-012 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-013 SHALL have port fil, input, DATA_WIDTH*RESULT_D*IMG_D*FILTER_L bits: the weights, with filter k in slice k, channel d within that, then tap l.
REQ-014 SHALL have port val_in, input, 1 bit, and port rdy_in, output, 1 bit: the job-start handshake.
REQ-015 SHALL have port img_rdaddr, output, IMG_RAM_ADDR_WIDTH*IMG_D bits: one identical copy per channel BRAM.
REQ-016 SHALL have port img_rddata, input, DATA_WIDTH*IMG_D bits: BRAM read data, valid one cycle after its address.
REQ-017 SHALL have port result_wraddr, output, RESULT_RAM_ADDR_WIDTH*RESULT_D bits: one identical copy per output channel.
REQ-018 SHALL have port result_wrdata, output, DATA_WIDTH*RESULT_D bits: result k in slice k.
REQ-019 SHALL have port result_wren, output, RESULT_D bits: all bits always equal.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse marking job completion.

Function
REQ-021 SHALL compute out[k][w] = sum over d and l of fil[k][d][l]*img[d][w*STRIDE_W+l*DILATION-PAD], where any column index below 0 or at/above IMG_W contributes 0.
REQ-022 SHALL accumulate at full precision in ACC_W = 2*DATA_WIDTH+$clog2(IMG_D*FILTER_L+1) bits, then reduce to DATA_WIDTH bits by wrap or clamp per SATURATE.
REQ-023 SHALL use the state machine IDLE, RUN, ACC, WR, DONE.
REQ-024 SHALL assert rdy_in only in IDLE, accept a job on val_in&&rdy_in, latch fil on that edge, and set w=0, l=0 and the accumulators to 0.
REQ-025 SHALL, in RUN, issue tap l of output w each cycle, l=0..FILTER_L-1, then move to ACC.
REQ-026 SHALL, for a padded tap, hold img_rdaddr at its previous value and zero that tap's contribution one cycle later.
REQ-027 SHALL accumulate the read data in the cycle after each address, so the last tap is added in ACC.
REQ-028 SHALL, in WR, assert result_wren for exactly one cycle with result_wraddr=w and the reduced result, then clear the accumulators.
REQ-029 SHALL leave WR for RUN with w+1 if w<RESULT_W-1, or for DONE otherwise.
REQ-030 SHALL assert done for one cycle in DONE, then return to IDLE.
REQ-031 SHALL, for a job accepted at edge T, write output w at cycle T+(w+1)*(FILTER_L+2) and pulse done at cycle T+RESULT_W*(FILTER_L+2)+1.
REQ-032 SHALL ignore val_in while busy, hold result_wren at 0 outside WR, and not alter the latched weights when fil changes mid-job.
REQ-033 SHALL allow back-to-back jobs: with val_in held high, the next job is accepted on the first IDLE cycle after DONE.

Reset
REQ-034 SHALL, with reset low at a clk edge, enter IDLE and clear w, l, the accumulators and the latched weights.
REQ-035 SHALL reset these outputs: rdy_in=1, done=0, result_wren=0, and img_rdaddr, result_wraddr and result_wrdata all 0.
REQ-036 SHALL abandon a job on reset mid-operation, with no further writes and no done pulse.

Structure
REQ-037 SHALL place the state enum, the ACC_W function and the saturation function in shared package conv_1d_pkg.
REQ-038 SHALL instantiate RESULT_D copies of sub-module conv_bram_1d_pad_mac, each holding one filter, one accumulator and the reduction.
REQ-039 SHALL keep addressing, padding and state logic in a single shared controller inside conv_bram_1d_pad.

Verification
REQ-040 SHALL cover the base case: defaults, all pixels 1, all weights 1 -> RESULT_W=30, every result 12, writes spaced 5 cycles apart, done after 30 writes.
REQ-041 SHALL cover padding: IMG_W=8, PAD=1, all pixels and weights 1 -> RESULT_W=8, out[0]=out[7]=8 (IMG_D=4), interior outputs 12, and no read ever issued at a padded tap.
REQ-042 SHALL cover stride and dilation: IMG_W=16, STRIDE_W=2, DILATION=2, IMG_D=1, RESULT_D=1, weights 1, img[x]=x -> RESULT_W=6, out[w]=6w+6.
REQ-043 SHALL cover saturation: DATA_WIDTH=8, pixels 127, weights 127 -> 127 with SATURATE=1, and the low 8 bits of the sum with SATURATE=0.
REQ-044 SHALL cover handshakes: reset low during RUN of output 3 -> rdy_in=1 the next cycle, no writes and no done; val_in while busy is ignored.
REQ-045 SHALL cover back-to-back jobs: val_in held high -> second job accepted the cycle after DONE, with weights changed between jobs applied only to the second job.
